axi_slv_burst_addr_gen: RTL and testbench
=========================================

// Module: axi_slv_burst_addr_gen
// PURPOSE
//  Subordinate-side AXI4 burst decoder. It accepts one AW/AR command and expands it into per-beat addresses.
//  Each beat also carries a response code and a last flag, for FIXED, INCR and WRAP bursts.
//  Sits between the subordinate's AW/AR channel and its W/R data path (memory model, register slave).
// PARAMETERS
//  AXI_ADDR_WIDTH  32  address width, bits
//  AXI_DATA_WIDTH  64  data bus width, bits (8..1024, power of 2); caps legal size at log2(AXI_DATA_WIDTH/8)
//  AXI_ID_WIDTH    4   transaction ID width
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               reset, asynchronous, active-high
//  cmd_valid_i  in   1               command valid
//  cmd_ready_o  out  1               command ready
//  cmd_id_i     in   AXI_ID_WIDTH    AxID
//  cmd_addr_i   in   AXI_ADDR_WIDTH  AxADDR (start address)
//  cmd_len_i    in   8               AxLEN (beats-1)
//  cmd_size_i   in   3               AxSIZE (bytes/beat = 2**size)
//  cmd_burst_i  in   2               AxBURST: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  beat_valid_o out  1               beat valid
//  beat_ready_i in   1               beat accepted by data path
//  beat_id_o    out  AXI_ID_WIDTH    ID of current burst
//  beat_addr_o  out  AXI_ADDR_WIDTH  address of current beat
//  beat_idx_o   out  8               beat index, 0..len
//  beat_last_o  out  1               current beat is beat len
//  beat_resp_o  out  2               00 OKAY, 10 SLAVE_ERROR
//  busy_o       out  1               burst in progress
// BEHAVIOUR
//  Reset: one clock, asynchronous active-high reset. While rst_i is high, all outputs are 0 and the FSM is in IDLE.
//  Reset mid-burst: the burst is abandoned and no further beats are issued. cmd_ready_o=1 from the first cycle after release.
//  FSM IDLE -> BURST on cmd_valid_i&cmd_ready_o. BURST -> IDLE on a beat handshake with beat_last_o and no new command.
//  BURST -> BURST (new burst) when the last-beat handshake and a command handshake occur in the same cycle.
//  cmd_ready_o = (state==IDLE) | (beat_valid_o & beat_ready_i & beat_last_o). Gives zero-bubble back-to-back bursts.
//  Latency: beat 0 is valid in the cycle after command acceptance. Beat outputs are registered.
//  Beat outputs hold stable while beat_valid_o & !beat_ready_i. Each handshake advances to the next beat in the next cycle.
//  beat_valid_o = (state==BURST). busy_o = beat_valid_o.
//  Address rules (A=start, N=2**size, aligned=A & ~(N-1)):
//   - FIXED: every beat = A.
//   - INCR: beat0 = A (unaligned allowed); beat n = aligned + n*N.
//   - WRAP: W=(len+1)*N, lower = A & ~(W-1); next = cur+N; if next == lower+W then next = lower.
//   - All sums are modulo 2**AXI_ADDR_WIDTH; wrap-around past the top of the address space is silent.
//  Errors, decided at acceptance:
//   - burst==11
//   - WRAP with len not in {1,3,7,15}
//   - WRAP with A not N-aligned
//   - size > log2(AXI_DATA_WIDTH/8)
//  Error bursts: all len+1 beats are still issued, each with beat_addr_o=A and beat_resp_o=10. Otherwise beat_resp_o=00.
//  len=0: a single beat with beat_last_o=1 and beat_idx_o=0.
// CONFIGURATION
//  AXI_BURST_4KB_CHECK_EN defined: an INCR burst is an error when (aligned + (len+1)*N - 1)[AW-1:12] != A[AW-1:12].
//   Such a burst follows the error-burst rules above (addr=A, resp=10 on every beat).
//  AXI_BURST_4KB_CHECK_EN undefined: no 4KB check; addresses cross the boundary normally with OKAY.
// TESTING
//  1. INCR A=0x1004 len=3 size=2 -> addrs 0x1004,0x1008,0x100C,0x1010; idx 0..3; last on idx3; resp 00.
//  2. WRAP A=0x38 len=3 size=3 (DATA 64) -> 0x38,0x20,0x28,0x30; last on 0x30; resp 00.
//  3. FIXED A=0x200 len=2 -> three beats at 0x200. Then errors:
//     - burst=11 len=1 -> 2 beats resp 10
//     - WRAP len=2 -> 3 beats resp 10
//     - size=4 with DATA 64 -> resp 10
//  4. Random beat_ready_i backpressure on INCR len=7; outputs stable while stalled.
//     Second command presented during the last beat: accepted in the last-handshake cycle, its beat0 valid in the next cycle.
//  5. INCR A=0xFF8 len=1 size=3:
//     - with AXI_BURST_4KB_CHECK_EN: two beats at 0xFF8, resp 10
//     - without: 0xFF8,0x1000, resp 00
//  6. rst_i pulsed after beat1 of a len=7 burst -> beat_valid_o=0 immediately; no further beats; cmd_ready_o=1 the cycle after release.

Source files
------------

// File: rtl/axi_slv_burst_addr_gen.sv
// Subordinate-side AXI4 burst decoder: expands one AW/AR command into per-beat address/idx/last/resp.
// Optional macro AXI_BURST_4KB_CHECK_EN flags INCR bursts that cross a 4KB page as errors.
module axi_slv_burst_addr_gen #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]                cmd_len_i,
  input  logic [2:0]                cmd_size_i,
  input  logic [1:0]                cmd_burst_i,
  output logic                      beat_valid_o,
  input  logic                      beat_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   beat_id_o,
  output logic [AXI_ADDR_WIDTH-1:0] beat_addr_o,
  output logic [7:0]                beat_idx_o,
  output logic                      beat_last_o,
  output logic [1:0]                beat_resp_o,
  output logic                      busy_o,
  output logic                      dbg_state_o
);
  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both high;
  // a beat, once valid, holds every output stable until it is accepted.
  localparam int AW = AXI_ADDR_WIDTH;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  state_t state, state_nxt;

  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]           addr_q, addr_nxt, nbytes_q, wmask_q;
  logic [7:0]              idx_q, len_q;
  logic [1:0]              mode_q, resp_q;

  logic          beat_hs, cmd_hs, err, cross_4k, wrap_len_ok;
  logic [AW-1:0] nbytes, span;

  assign beat_valid_o = (state == BURST);
  assign busy_o       = beat_valid_o;
  assign dbg_state_o  = state;
  assign beat_last_o  = beat_valid_o && (idx_q == len_q);
  assign beat_hs      = beat_valid_o && beat_ready_i;
  assign cmd_ready_o  = !rst_i && ((state == IDLE) || (beat_hs && beat_last_o));
  assign cmd_hs       = cmd_valid_i && cmd_ready_o;
  assign beat_id_o    = id_q;
  assign beat_addr_o  = addr_q;
  assign beat_idx_o   = idx_q;
  assign beat_resp_o  = resp_q;

  // Command decode: bytes per beat, total burst span and error classification.
  assign nbytes      = AW'(1) << cmd_size_i;
  assign span        = AW'({1'b0, cmd_len_i} + 9'd1) << cmd_size_i;
  assign wrap_len_ok = (cmd_len_i == 8'd1) || (cmd_len_i == 8'd3) ||
                       (cmd_len_i == 8'd7) || (cmd_len_i == 8'd15);

`ifdef AXI_BURST_4KB_CHECK_EN
  logic [AW-1:0] aligned, end_addr;
  assign aligned  = cmd_addr_i & ~(nbytes - AW'(1));
  assign end_addr = aligned + span - AW'(1);
  assign cross_4k = (cmd_burst_i == 2'b01) && (end_addr[AW-1:12] != cmd_addr_i[AW-1:12]);
`else
  assign cross_4k = 1'b0;
`endif

  assign err = (cmd_burst_i == 2'b11) ||
               ((cmd_burst_i == 2'b10) && (!wrap_len_ok || (|(cmd_addr_i & (nbytes - AW'(1)))))) ||
               (cmd_size_i > MAX_SIZE) || cross_4k;

  // Error bursts are loaded with mode 00 so they repeat the start address like FIXED.
  always_comb begin
    addr_nxt = addr_q;
    case (mode_q)
      2'b01:   addr_nxt = (addr_q & ~(nbytes_q - AW'(1))) + nbytes_q;
      2'b10:   addr_nxt = (addr_q & ~wmask_q) | ((addr_q + nbytes_q) & wmask_q);
      default: addr_nxt = addr_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs) state_nxt = BURST;
      BURST:   if (beat_hs && beat_last_o) state_nxt = cmd_hs ? BURST : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q     <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      nbytes_q <= '0;
      wmask_q  <= '0;
      mode_q   <= '0;
      resp_q   <= '0;
    end else if (cmd_hs) begin
      id_q     <= cmd_id_i;
      addr_q   <= cmd_addr_i;
      idx_q    <= '0;
      len_q    <= cmd_len_i;
      nbytes_q <= nbytes;
      wmask_q  <= span - AW'(1);
      mode_q   <= err ? 2'b00 : cmd_burst_i;
      resp_q   <= err ? 2'b10 : 2'b00;
    end else if (beat_hs) begin
      idx_q    <= idx_q + 8'd1;
      addr_q   <= addr_nxt;
    end
  end
endmodule

// File: tb/tb_axi_slv_burst_addr_gen.sv
// Directed bench for axi_slv_burst_addr_gen: expected beats queued at command issue, checked by a monitor.
module tb_axi_slv_burst_addr_gen;
  localparam int BW = 4 + 32 + 8 + 1 + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [1:0]  beat_resp;
  logic        busy;
  logic        dbg_state;

  logic [BW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;

  axi_slv_burst_addr_gen #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_id_i(cmd_id),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size), .cmd_burst_i(cmd_burst),
    .beat_valid_o(beat_valid), .beat_ready_i(beat_ready), .beat_id_o(beat_id),
    .beat_addr_o(beat_addr), .beat_idx_o(beat_idx), .beat_last_o(beat_last),
    .beat_resp_o(beat_resp), .busy_o(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input logic [3:0] id, input logic [31:0] addr,
                                         input logic [7:0] idx, input logic last, input logic [1:0] resp);
    return {id, addr, idx, last, resp};
  endfunction

  task automatic push_exp(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] idx,
                          input logic last, input logic [1:0] resp);
    exp_q.push_back(pack(id, addr, idx, last, resp));
  endtask

  // ready driver
  always @(posedge clk) begin
    #1;
    beat_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] exp;
    cur = pack(beat_id, beat_addr, beat_idx, beat_last, beat_resp);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {15'd0, beat_valid, cur}, {15'd0, 1'b1, prev_beat});
      if (beat_valid && beat_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got id=%0h addr=0x%0h idx=%0d, expected no beat",
                   beat_id, beat_addr, beat_idx);
        end else begin
          exp = exp_q.pop_front();
          checks++;
          if (cur !== exp) begin
            errors++;
            $display("FAIL beat: got id=%0h addr=0x%0h idx=%0d last=%0b resp=%0b, expected id=%0h addr=0x%0h idx=%0d last=%0b resp=%0b",
                     cur[46:43], cur[42:11], cur[10:3], cur[2], cur[1:0],
                     exp[46:43], exp[42:11], exp[10:3], exp[2], exp[1:0]);
          end
        end
      end
      prev_stall = beat_valid && !beat_ready;
      prev_beat  = cur;
    end
  end

  // command driver
  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1'b1;
        if (beat_valid) check("b2b_accept_on_last", {62'd0, beat_last, beat_ready}, 64'd3);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
      end
    end
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: got no cmd_ready, expected acceptance of id %0h", id);
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      check("beat0_latency", {51'd0, beat_valid, beat_idx, beat_id}, {51'd0, 1'b1, 8'd0, id});
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'd0, beat_valid}, 64'd0);
    check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_beat_fields"}, {17'd0, pack(beat_id, beat_addr, beat_idx, beat_last, beat_resp)}, 64'd0);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {62'd0, cmd_ready, beat_valid}, 64'd2);

    // INCR unaligned start
    for (int i = 0; i < 4; i++) push_exp(4'h1, 32'h1004 + 32'(i) * 4, 8'(i), i == 3, 2'b00);
    send_cmd(4'h1, 32'h1004, 8'd3, 3'd2, 2'b01);
    wait_idle();

    // WRAP
    push_exp(4'h2, 32'h38, 8'd0, 1'b0, 2'b00);
    push_exp(4'h2, 32'h20, 8'd1, 1'b0, 2'b00);
    push_exp(4'h2, 32'h28, 8'd2, 1'b0, 2'b00);
    push_exp(4'h2, 32'h30, 8'd3, 1'b1, 2'b00);
    send_cmd(4'h2, 32'h38, 8'd3, 3'd3, 2'b10);
    wait_idle();

    // FIXED
    for (int i = 0; i < 3; i++) push_exp(4'h3, 32'h200, 8'(i), i == 2, 2'b00);
    send_cmd(4'h3, 32'h200, 8'd2, 3'd2, 2'b00);
    wait_idle();

    // error bursts: reserved type, bad wrap len, oversize, unaligned wrap
    for (int i = 0; i < 2; i++) push_exp(4'h4, 32'h300, 8'(i), i == 1, 2'b10);
    send_cmd(4'h4, 32'h300, 8'd1, 3'd2, 2'b11);
    for (int i = 0; i < 3; i++) push_exp(4'h5, 32'h40, 8'(i), i == 2, 2'b10);
    send_cmd(4'h5, 32'h40, 8'd2, 3'd2, 2'b10);
    for (int i = 0; i < 2; i++) push_exp(4'h6, 32'h500, 8'(i), i == 1, 2'b10);
    send_cmd(4'h6, 32'h500, 8'd1, 3'd4, 2'b01);
    for (int i = 0; i < 2; i++) push_exp(4'h7, 32'h44, 8'(i), i == 1, 2'b10);
    send_cmd(4'h7, 32'h44, 8'd1, 3'd3, 2'b10);
    wait_idle();

    // single-beat burst
    push_exp(4'h8, 32'h123, 8'd0, 1'b1, 2'b00);
    send_cmd(4'h8, 32'h123, 8'd0, 3'd0, 2'b01);
    wait_idle();

    // backpressure plus a second command queued behind the last beat
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(4'h9, 32'h2000 + 32'(i) * 4, 8'(i), i == 7, 2'b00);
    send_cmd(4'h9, 32'h2000, 8'd7, 3'd2, 2'b01);
    push_exp(4'hA, 32'h3002, 8'd0, 1'b0, 2'b00);
    push_exp(4'hA, 32'h3004, 8'd1, 1'b1, 2'b00);
    send_cmd(4'hA, 32'h3002, 8'd1, 3'd1, 2'b01);
    wait_idle();
    rand_ready = 1'b0;

    // INCR across a 4KB page
`ifdef AXI_BURST_4KB_CHECK_EN
    push_exp(4'hB, 32'hFF8, 8'd0, 1'b0, 2'b10);
    push_exp(4'hB, 32'hFF8, 8'd1, 1'b1, 2'b10);
`else
    push_exp(4'hB, 32'hFF8, 8'd0, 1'b0, 2'b00);
    push_exp(4'hB, 32'h1000, 8'd1, 1'b1, 2'b00);
`endif
    send_cmd(4'hB, 32'hFF8, 8'd1, 3'd3, 2'b01);
    wait_idle();

    // reset mid-burst after beat 1
    push_exp(4'hC, 32'h4000, 8'd0, 1'b0, 2'b00);
    push_exp(4'hC, 32'h4004, 8'd1, 1'b0, 2'b00);
    send_cmd(4'hC, 32'h4000, 8'd7, 3'd2, 2'b01);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (beat_valid && beat_idx == 8'd1) seen = 1'b1;
      end
      check("reach_beat1", {63'd0, seen}, 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_valid_drop", {62'd0, beat_valid, cmd_ready}, 64'd0);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", {62'd0, cmd_ready, beat_valid}, 64'd2);
    repeat (12) @(negedge clk);
    check("no_beats_after_rst", {63'd0, busy}, 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
